mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, which sets busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, which sets busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted, acts immediately without a clock edge).
REQ-005 The block SHALL have port start, input, 1 bit: request to issue op this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 The block SHALL have port a, input, 32 bits: rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-008 The block SHALL have port b, input, 32 bits: rt operand (divisor / multiplier).
REQ-009 The block SHALL have port busy, output, 1 bit: a multiply/divide operation is in flight.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, HI/LO just updated by MULT/DIV.
REQ-011 The block SHALL have port hi, output, 32 bits: HI register.
REQ-012 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-013 The block SHALL implement FSM states IDLE and RUN; busy SHALL be 1 exactly when state is RUN.
REQ-014 The block SHALL accept a request only when start=1, state=IDLE and op is not reserved; requests arriving in RUN or carrying a reserved op SHALL be ignored with no state change.
REQ-015 On acceptance of MULT/MULTU/DIV/DIVU, the block SHALL latch a, b and op, enter RUN, and load its counter with (op is mult ? MULT_CYCLES : DIV_CYCLES) - 1.
REQ-016 In RUN with counter not equal to 0, the block SHALL decrement the counter each cycle; a, b, hi and lo SHALL then hold.
REQ-017 In RUN with counter equal to 0, the next edge SHALL write the result to hi/lo, return the FSM to IDLE, and set done=1 for exactly that following cycle; busy is therefore high for exactly N cycles after the accept edge.
REQ-018 MULT SHALL compute the signed 32x32 to 64-bit product, and MULTU the unsigned product; hi receives product[63:32] and lo receives product[31:0].
REQ-019 DIV SHALL be signed with the quotient truncated toward zero and the remainder taking the sign of the dividend; DIVU SHALL be unsigned; lo receives the quotient and hi the remainder.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0x00000000.
REQ-021 DIV/DIVU with b=0 SHALL run the full DIV_CYCLES and pulse done, but hi and lo SHALL stay unchanged.
REQ-022 An accepted MTHI SHALL write hi<=a on the accept edge (and MTLO SHALL write lo<=a); neither SHALL assert busy or done, and the FSM SHALL stay IDLE.
REQ-023 A new request is acceptable in the same cycle that done=1, because the FSM is already IDLE, giving back-to-back issue with no gap cycle.
REQ-024 The arithmetic SHALL use latched operands only; changes on a/b during RUN SHALL not affect the result.
REQ-025 hi and lo SHALL be readable combinationally from their registers at all times; while busy they SHALL show the previous values.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0x00000000, lo=0x00000000, and clear the latched operands.
REQ-027 Reset asserted mid-operation SHALL abort the operation: no done pulse and no HI/LO write SHALL occur after reset is released.
REQ-028 After reset is released, the first rising edge SHALL be able to accept a request.

Verification
REQ-029 The bench SHALL cover MULT with a=0xFFFFFFFE (-2) and b=0x00000003 -> busy high for 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-030 The bench SHALL cover DIV with a=0xFFFFFFF9 (-7) and b=0x00000002 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-031 The bench SHALL cover DIV by zero with hi/lo preloaded by MTHI 0x11111111 and MTLO 0x22222222 -> done after 10 cycles, hi/lo unchanged; MTHI/MTLO themselves update on the accept edge with busy staying 0.
REQ-032 The bench SHALL cover start with MTLO 0x5 while a MULT is in flight -> ignored: lo is the MULT result, not 5; a second MULT issued in the done cycle -> accepted, busy high again the next cycle.
REQ-033 The bench SHALL cover reset=0 pulsed for a fraction of a cycle at DIV cycle 4 -> busy=0, hi=lo=0 immediately, and no done pulse follows.
REQ-034 The bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; and a reserved op=110 with start=1 -> no state change.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: a fixed-latency MULT/DIV engine with the
// HI/LO register pair, plus single-cycle MTHI/MTLO writes.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Handshake: a request is taken on a rising edge where start=1, busy=0 and
  // op is not reserved. MULT/DIV raise busy for exactly N cycles and then
  // pulse done for one cycle with HI/LO already updated. A new request may be
  // presented in the done cycle. MTHI/MTLO complete on the accept edge.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;   // bit1: divide, bit0: unsigned
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Results come only from the latched operands, never from the live inputs.
  always_comb begin
    a_ext   = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext   = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod    = a_ext * b_ext;
    a_neg   = ~op_q[0] & a_q[31];
    b_neg   = ~op_q[0] & b_q[31];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    // Sign-magnitude division: 0x80000000 / -1 wraps back to 0x80000000.
    quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 2'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
                state <= RUN;
              end
              3'b100:  hi_q <= a;
              3'b101:  lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= IDLE;
            done_q <= 1'b1;
            if (!op_q[1]) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus random ops, with results
// predicted by an arithmetic reference model and checked by a done monitor.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: HI/LO after an op, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    p = {mh, ml};
    case (o)
      3'd0: begin
        sx = $signed(x);
        sy = $signed(y);
        p  = 64'(sx * sy);
      end
      3'd1: p = {32'b0, x} * {32'b0, y};
      3'd2: if (y != 0) begin
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        p  = {r[31:0], q[31:0]};
      end
      3'd3: if (y != 0) p = {x % y, x / y};
      default: p = {mh, ml};
    endcase
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest expected result and cycle.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    int ec;
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_hilo", {hi, lo}, e);
        check("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // Driver: called at a falling edge, returns at a falling edge. With poke set,
  // an MTLO of 5 is presented during the run and must be ignored.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    logic [63:0] r;
    int n;
    int cnt;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (o <= 3'd3) begin
      r = model(o, x, y);
      n = o[1] ? 10 : 5;
      exp_q.push_back(r);
      exp_cyc_q.push_back(cyc + n);
      mh  = r[63:32];
      ml  = r[31:0];
      cnt = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        if (busy) begin
          cnt++;
          if (poke && cnt == 2) begin
            start = 1'b1;
            op    = 3'b101;
            a     = 32'h5;
          end
        end
      end while (busy && cnt < 40);
      check("busy_cycles", 64'(cnt), 64'(n));
    end else begin
      if (o == 3'd4) mh = x;
      else if (o == 3'd5) ml = x;
      check("imm_busy", {63'd0, busy}, 64'd0);
      check("imm_done", {63'd0, done}, 64'd0);
      check("imm_hilo", {hi, lo}, {mh, ml});
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Issued right away: the first edge after release must accept.
    do_op(3'd0, 32'hFFFFFFFE, 32'h3, 1'b0);
    check("mult_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    do_op(3'd1, 32'hFFFFFFFE, 32'h3, 1'b0);
    check("multu_const", {hi, lo}, {32'h00000002, 32'hFFFFFFFA});
    do_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b0);
    check("div_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    check("divu_const", {hi, lo}, {32'd1, 32'd3});

    do_op(3'd4, 32'h11111111, 32'h0, 1'b0);
    do_op(3'd5, 32'h22222222, 32'h0, 1'b0);
    do_op(3'd2, 32'h00001234, 32'h0, 1'b0);
    check("div0_const", {hi, lo}, {32'h11111111, 32'h22222222});

    do_op(3'd0, 32'd7, 32'd9, 1'b1);
    check("mtlo_ignored", {hi, lo}, {32'd0, 32'd63});
    do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("b2b_const", {hi, lo}, {32'd0, 32'd1});

    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_const", {hi, lo}, {32'h00000000, 32'h80000000});
    do_op(3'd6, 32'hDEADBEEF, 32'h1, 1'b0);
    do_op(3'd7, 32'hCAFEF00D, 32'h1, 1'b0);

    // Abort a DIV with a sub-cycle reset pulse.
    start = 1'b1;
    op    = 3'd2;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    #1;
    reset = 1'b1;
    mh = 32'd0;
    ml = 32'd0;
    repeat (15) @(negedge clk);
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    check("abort_idle_hilo", {hi, lo}, 64'd0);

    do_op(3'd3, 32'd100, 32'd7, 1'b0);
    check("post_abort_divu", {hi, lo}, {32'd2, 32'd14});

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) x = 32'h80000000;
      do_op(o, x, y, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
